mem_lsu: RTL and testbench

//  Parametrised load/store unit replacing the combinational MEM stage. Accepts one op from EX
//  by valid/ready and drives a req/gnt/rvalid RAM port. Handles multi-cycle RAM latency and

---
 rtl/mem_lsu_pkg.sv | 20 ++
 rtl/mem_lsu_align.sv | 53 +++++
 rtl/mem_lsu.sv | 178 +++++++++++++++++
 tb/tb_mem_lsu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared size codes, FSM states and lane-offset helper for mem_lsu
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Number of byte-offset bits inside one RAM word.
  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - store lane alignment, load extract/extend and misalign detect
module mem_lsu_align import mem_lsu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  localparam int LANES = DATA_WIDTH / 8,
  localparam int OFF = off_bits(DATA_WIDTH)
) (
  input  logic [1:0]            size,
  input  logic [OFF-1:0]        off,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [LANES-1:0]      be,
  output logic [DATA_WIDTH-1:0] wdata_lane,
  output logic                  misalign,
  input  logic [1:0]            ld_size,
  input  logic [OFF-1:0]        ld_off,
  input  logic                  ld_signed,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [LANES-1:0]      mask;
  logic [2:0]            off3;
  logic [DATA_WIDTH-1:0] sh;

  assign off3       = 3'(off);
  assign be         = mask << off;
  assign wdata_lane = wdata << {off, 3'b000};
  assign sh         = rdata >> {ld_off, 3'b000};

  always_comb begin
    mask     = '0;
    misalign = 1'b0;
    case (size)
      SZ_B: begin mask = LANES'(1);  misalign = 1'b0; end
      SZ_H: begin mask = LANES'(3);  misalign = off3[0]; end
      SZ_W: begin mask = LANES'(15); misalign = |off3[1:0]; end
      default: begin
        mask     = '1;
        misalign = (DATA_WIDTH == 32) ? 1'b1 : |off3;
      end
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SZ_B: ld_data = ld_signed ? DATA_WIDTH'($signed(sh[7:0]))  : DATA_WIDTH'(sh[7:0]);
      SZ_H: ld_data = ld_signed ? DATA_WIDTH'($signed(sh[15:0])) : DATA_WIDTH'(sh[15:0]);
      SZ_W: ld_data = ld_signed ? DATA_WIDTH'($signed(sh[31:0])) : DATA_WIDTH'(sh[31:0]);
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit with req/gnt/rvalid RAM port; option MEM_LSU_MISALIGN_EXC_EN
module mem_lsu import mem_lsu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int LANES = DATA_WIDTH / 8,
  localparam int OFF = off_bits(DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_read,
  input  logic                      in_write,
  input  logic                      in_signed,
  input  logic [1:0]                in_size,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  input  logic                      in_reg_we,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_waddr,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  output logic                      ram_req,
  input  logic                      ram_gnt,
  output logic                      ram_we,
  output logic [LANES-1:0]          ram_be,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic                      ram_rvalid,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      out_valid,
  output logic                      out_reg_we,
  output logic [REG_ADDR_WIDTH-1:0] out_reg_waddr,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic                      load_pending,
  output logic                      excp_misalign,
  output logic [ADDR_WIDTH-1:0]     excp_addr
);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]     addr;
  logic                      mem_op, misalign, skip, accept;
  logic [LANES-1:0]          be;
  logic [DATA_WIDTH-1:0]     wdata_lane, ld_data;

  logic                      lat_read, lat_signed, lat_reg_we, lat_mis;
  logic [1:0]                lat_size;
  logic [OFF-1:0]            lat_off;
  logic [REG_ADDR_WIDTH-1:0] lat_reg_waddr;
  logic [ADDR_WIDTH-1:0]     lat_pc;
  logic [DATA_WIDTH-1:0]     lat_result;

  assign addr         = ADDR_WIDTH'(in_result);
  assign mem_op       = in_read | in_write;
  assign in_ready     = (state == ST_IDLE);
  assign accept       = in_valid & in_ready;
  assign load_pending = (state != ST_IDLE) & lat_read;

  mem_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size       (in_size),
    .off        (addr[OFF-1:0]),
    .wdata      (in_wdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .misalign   (misalign),
    .ld_size    (lat_size),
    .ld_off     (lat_off),
    .ld_signed  (lat_signed),
    .rdata      (ram_rdata),
    .ld_data    (ld_data)
  );

`ifdef MEM_LSU_MISALIGN_EXC_EN
  // A misaligned op never reaches the RAM; it retires from IDLE as a fault.
  assign skip = mem_op & misalign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      excp_misalign <= 1'b0;
      excp_addr     <= '0;
    end else begin
      excp_misalign <= 1'b0;
      if (accept && skip) begin
        excp_misalign <= 1'b1;
        excp_addr     <= addr;
      end
    end
  end
`else
  assign skip          = 1'b0;
  assign excp_misalign = 1'b0;
  assign excp_addr     = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && mem_op && !skip) state_next = ST_REQ;
      ST_REQ:  if (ram_gnt) state_next = ram_we ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (ram_rvalid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_req       <= 1'b0;
      ram_we        <= 1'b0;
      ram_be        <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      out_valid     <= 1'b0;
      out_reg_we    <= 1'b0;
      out_reg_waddr <= '0;
      out_result    <= '0;
      out_pc        <= '0;
      lat_read      <= 1'b0;
      lat_signed    <= 1'b0;
      lat_reg_we    <= 1'b0;
      lat_mis       <= 1'b0;
      lat_size      <= '0;
      lat_off       <= '0;
      lat_reg_waddr <= '0;
      lat_pc        <= '0;
      lat_result    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        lat_read      <= in_read & ~in_write;
        lat_signed    <= in_signed;
        lat_reg_we    <= in_reg_we;
        lat_mis       <= misalign;
        lat_size      <= in_size;
        lat_off       <= addr[OFF-1:0];
        lat_reg_waddr <= in_reg_waddr;
        lat_pc        <= in_pc;
        lat_result    <= in_result;
        if (!mem_op || skip) begin
          out_valid     <= 1'b1;
          out_reg_we    <= in_reg_we & ~skip;
          out_reg_waddr <= in_reg_waddr;
          out_result    <= in_result;
          out_pc        <= in_pc;
        end else begin
          ram_req   <= 1'b1;
          ram_we    <= in_write;
          ram_addr  <= {addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          ram_be    <= misalign ? '0 : be;
          ram_wdata <= wdata_lane;
        end
      end
      if (state == ST_REQ && ram_gnt) begin
        ram_req <= 1'b0;
        if (ram_we) begin
          out_valid     <= 1'b1;
          out_reg_we    <= 1'b0;
          out_reg_waddr <= lat_reg_waddr;
          out_result    <= lat_result;
          out_pc        <= lat_pc;
        end
      end
      if (state == ST_WAIT && ram_rvalid) begin
        out_valid     <= 1'b1;
        out_reg_we    <= lat_reg_we;
        out_reg_waddr <= lat_reg_waddr;
        out_result    <= lat_mis ? '0 : ld_data;
        out_pc        <= lat_pc;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu with behavioural writeback model
module tb_mem_lsu;

`ifdef MEM_LSU_MISALIGN_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 0, in_ready, in_read = 0, in_write = 0, in_signed = 0;
  logic [1:0]  in_size = 0;
  logic [31:0] in_result = 0, in_wdata = 0, in_pc = 0;
  logic        in_reg_we = 0;
  logic [4:0]  in_reg_waddr = 0;
  logic        ram_req, ram_gnt = 0, ram_we, ram_rvalid = 0;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata = 0;
  logic        out_valid, out_reg_we, load_pending, excp_misalign;
  logic [4:0]  out_reg_waddr;
  logic [31:0] out_result, out_pc, excp_addr;

  mem_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read),
    .in_write(in_write), .in_signed(in_signed), .in_size(in_size), .in_result(in_result),
    .in_wdata(in_wdata), .in_reg_we(in_reg_we), .in_reg_waddr(in_reg_waddr), .in_pc(in_pc),
    .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_reg_we(out_reg_we), .out_reg_waddr(out_reg_waddr),
    .out_result(out_result), .out_pc(out_pc), .load_pending(load_pending),
    .excp_misalign(excp_misalign), .excp_addr(excp_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reg_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [31:0] pc;
    logic        excp;
    logic [31:0] eaddr;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        cmp_e;
  int          checks = 0, errors = 0, cyc = 0;
  bit          chk_en = 0, exp_busy = 0, exp_load = 0, exp_req = 0;
  logic [31:0] last_fault = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_mis(input int sz, input int unsigned a);
    return (sz == 3) || (a % (1 << sz) != 0);
  endfunction

  function automatic logic [3:0] m_be(input int sz, input int unsigned a);
    longint unsigned v;
    if (m_mis(sz, a)) return 4'd0;
    v = ((64'd1 << (1 << sz)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input int unsigned a, input logic [31:0] w);
    longint unsigned v;
    v = longint'(w) << (8 * (a % 4));
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit sg, input int unsigned a,
                                         input logic [31:0] rd);
    longint unsigned d, nb, keep;
    if (m_mis(sz, a)) return 32'd0;
    nb   = 8 << sz;
    d    = longint'(rd) >> (8 * (a % 4));
    keep = d % (64'd1 << nb);
    if (sg && keep >= (64'd1 << (nb - 1))) keep = keep - (64'd1 << nb);
    return 32'(keep);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !exp_busy);
      chk("ram_req", ram_req, exp_req);
      chk("load_pending", load_pending, exp_busy && exp_load);
      chk("excp_without_valid", excp_misalign & ~out_valid, 0);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        cmp_e = q.pop_front();
        chk("out_valid", out_valid, 1);
        chk("out_reg_we", out_reg_we, cmp_e.reg_we);
        chk("out_reg_waddr", out_reg_waddr, cmp_e.waddr);
        chk("out_result", out_result, cmp_e.result);
        chk("out_pc", out_pc, cmp_e.pc);
        chk("excp_misalign", excp_misalign, cmp_e.excp);
        if (cmp_e.excp) last_fault = cmp_e.eaddr;
        chk("excp_addr", excp_addr, last_fault);
      end else begin
        chk("out_valid_idle", out_valid, 0);
      end
    end
  end

  task automatic do_op(input bit rd, input bit wr, input bit sg, input int sz,
                       input int unsigned a, input logic [31:0] wd, input bit rwe,
                       input int wa, input int unsigned pc, input int g, input int r,
                       input logic [31:0] rdat);
    exp_t e;
    bit mem, skip;
    int acc;
    mem  = rd || wr;
    skip = EXC && mem && m_mis(sz, a);
    in_valid = 1; in_read = rd; in_write = wr; in_signed = sg; in_size = 2'(sz);
    in_result = a; in_wdata = wd; in_reg_we = rwe; in_reg_waddr = 5'(wa); in_pc = pc;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
    e.pc = pc; e.waddr = 5'(wa); e.excp = skip; e.eaddr = a; e.result = a; e.reg_we = rwe;
    if (skip) begin e.reg_we = 0; e.cyc = acc; end
    else if (!mem) e.cyc = acc;
    else if (wr) begin e.reg_we = 0; e.cyc = acc + 1 + g; end
    else begin e.result = m_load(sz, sg, a, rdat); e.cyc = acc + 2 + g + r; end
    q.push_back(e);
    if (mem && !skip) begin
      exp_busy = 1; exp_load = !wr; exp_req = 1;
      for (int k = 0; k <= g; k++) begin
        if (k == g) ram_gnt = 1;
        @(negedge clk);
        chk("ram_addr", ram_addr, a & ~32'd3);
        chk("ram_be", ram_be, m_be(sz, a));
        chk("ram_wdata", ram_wdata, m_wdata(a, wd));
        chk("ram_we", ram_we, wr);
        @(posedge clk); #1;
      end
      ram_gnt = 0; exp_req = 0;
      if (wr) exp_busy = 0;
      else begin
        for (int k = 0; k < r; k++) begin @(posedge clk); #1; end
        ram_rvalid = 1; ram_rdata = rdat;
        @(posedge clk); #1;
        ram_rvalid = 0; ram_rdata = 0; exp_busy = 0; exp_load = 0;
      end
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_ram_req"}, ram_req, 0);
    chk({tag, "_ram_be"}, ram_be, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_load_pending"}, load_pending, 0);
    chk({tag, "_excp"}, {excp_misalign, excp_addr}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chk("pin_be_sw", m_be(2, 'h104), 4'b1111);
    chk("pin_be_sb", m_be(0, 'h107), 4'b1000);
    chk("pin_wd_sb", m_wdata('h107, 32'hAB), 32'hAB00_0000);
    chk("pin_lh", m_load(1, 1, 'h102, 32'h8001_0000), 32'hFFFF_8001);
    chk("pin_lbu", m_load(0, 0, 'h101, 32'h0000_F100), 32'h0000_00F1);
    chk("pin_mis_lw", m_mis(2, 'h102), 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 1; chk_en = 1;
    @(posedge clk); #1;

    do_op(0, 1, 0, 2, 'h104, 32'h1234_5678, 1, 3, 'h1000, 0, 0, 0);
    do_op(0, 1, 0, 0, 'h107, 32'h0000_00AB, 1, 4, 'h1004, 0, 0, 0);
    do_op(1, 0, 1, 1, 'h102, 0, 1, 5, 'h1008, 1, 0, 32'h8001_0000);
    do_op(1, 0, 0, 0, 'h101, 0, 1, 6, 'h100C, 0, 4, 32'h0000_F100);
    do_op(1, 0, 0, 2, 'h102, 0, 1, 7, 'h1010, 0, 0, 32'hDEAD_BEEF);
    do_op(0, 0, 0, 0, 'hFFFF_0001, 0, 1, 8, 'h1014, 0, 0, 0);
    do_op(0, 0, 0, 0, 'h0000_0022, 0, 0, 9, 'h1018, 0, 0, 0);
    do_op(0, 0, 0, 0, 'h8000_0003, 0, 1, 10, 'h101C, 0, 0, 0);
    do_op(0, 1, 0, 1, 'h20A, 32'h0000_BEEF, 1, 11, 'h1020, 3, 0, 0);
    do_op(1, 1, 0, 2, 'h40, 32'hA5A5_5A5A, 1, 12, 'h1024, 0, 0, 32'h1111_1111);
    do_op(1, 0, 1, 0, 'h203, 0, 1, 13, 'h1028, 2, 1, 32'h80CC_DDEE);
    do_op(1, 0, 0, 2, 'h200, 0, 1, 14, 'h102C, 0, 0, 32'hCAFE_F00D);
    do_op(0, 1, 0, 3, 'h100, 32'h7777_7777, 0, 15, 'h1030, 0, 0, 0);

    // Stray rvalid while idle must not produce a writeback.
    ram_rvalid = 1; ram_rdata = 32'hFFFF_FFFF;
    repeat (2) begin @(posedge clk); #1; end
    ram_rvalid = 0; ram_rdata = 0;

    // Abort a load in WAIT with reset, then deliver its late rvalid.
    in_valid = 1; in_read = 1; in_write = 0; in_size = 2; in_result = 'h300; in_reg_we = 1;
    @(posedge clk); #1;
    in_valid = 0; exp_busy = 1; exp_load = 1; exp_req = 1; ram_gnt = 1;
    @(posedge clk); #1;
    ram_gnt = 0; exp_req = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    exp_busy = 0; exp_load = 0; last_fault = 0;
    rst = 1; ram_rvalid = 1; ram_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    ram_rvalid = 0;
    @(negedge clk);
    chk_idle_zero("abort");

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
